// File: rtl/colour_centroid_tracker.sv
// Colour-object locator: HSV window threshold, per-frame coordinate sums, sequential centroid divide.
// Optional bounding-box tracking is enabled with `define COLOUR_CENTROID_BBOX_EN.
module colour_centroid_tracker #(
  parameter int unsigned X_W       = 11,
  parameter int unsigned Y_W       = 11,
  parameter int unsigned CNT_W     = 19,
  parameter int unsigned SUM_W     = 28,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iDVAL,
  input  logic [X_W-1:0]   iX,
  input  logic [Y_W-1:0]   iY,
  input  logic             iVS,
  input  logic [7:0]       iH,
  input  logic [7:0]       iS,
  input  logic [7:0]       iV,
  input  logic [7:0]       iH_LO,
  input  logic [7:0]       iH_HI,
  input  logic [7:0]       iS_MIN,
  input  logic [7:0]       iV_MIN,
  output logic             oMASK,
  output logic [X_W-1:0]   oCX,
  output logic [Y_W-1:0]   oCY,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oFOUND,
  output logic             oVALID,
  output logic             oBUSY,
  output logic             oDROP,
  output logic [X_W-1:0]   oXMIN,
  output logic [X_W-1:0]   oXMAX,
  output logic [Y_W-1:0]   oYMIN,
  output logic [Y_W-1:0]   oYMAX
);

  localparam int unsigned SUM_EW = SUM_W + 1;
  localparam int unsigned REM_EW = CNT_W + 1;
  localparam int unsigned STEP_W = $clog2(SUM_W);

  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, DONE} state_t;

  state_t state, next_state;

  logic              vs_q;
  logic [CNT_W-1:0]  cnt_acc;
  logic [SUM_W-1:0]  sx_acc, sy_acc;
  logic [CNT_W-1:0]  snap_cnt;
  logic [SUM_W-1:0]  snap_sy;
  logic [SUM_W-1:0]  div_quo;
  logic [CNT_W-1:0]  div_rem;
  logic [STEP_W-1:0] step;
  logic [X_W-1:0]    quot_x;

  logic              hue_ok_c, match_c, frame_end_c, last_step_c, found_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [SUM_EW-1:0] sx_add_c, sy_add_c;
  logic [SUM_W-1:0]  sx_inc_c, sy_inc_c;
  logic [REM_EW-1:0] rem_shift_c, rem_sub_c;
  logic              rem_ge_c;
  logic [CNT_W-1:0]  rem_next_c;
  logic [SUM_W-1:0]  quo_next_c;

  // Pixel classification; a wrapped hue window (LO > HI) covers the red end of the wheel.
  always_comb begin
    if (iH_LO <= iH_HI) hue_ok_c = (iH >= iH_LO) && (iH <= iH_HI);
    else                hue_ok_c = (iH >= iH_LO) || (iH <= iH_HI);
  end

  assign match_c     = iDVAL & hue_ok_c & (iS >= iS_MIN) & (iV >= iV_MIN);
  assign frame_end_c = vs_q & ~iVS;
  assign found_c     = cnt_acc >= CNT_W'(MIN_COUNT);
  assign last_step_c = step == STEP_W'(SUM_W - 1);

  // Saturating accumulator increments
  assign cnt_inc_c = (cnt_acc == '1) ? cnt_acc : cnt_acc + CNT_W'(1);
  assign sx_add_c  = {1'b0, sx_acc} + SUM_EW'(iX);
  assign sy_add_c  = {1'b0, sy_acc} + SUM_EW'(iY);
  assign sx_inc_c  = sx_add_c[SUM_W] ? '1 : sx_add_c[SUM_W-1:0];
  assign sy_inc_c  = sy_add_c[SUM_W] ? '1 : sy_add_c[SUM_W-1:0];

  // One restoring-division step: the quotient bit shifts in as the dividend bit shifts out.
  assign rem_shift_c = {div_rem, div_quo[SUM_W-1]};
  assign rem_ge_c    = rem_shift_c >= {1'b0, snap_cnt};
  assign rem_sub_c   = rem_shift_c - {1'b0, snap_cnt};
  assign rem_next_c  = rem_ge_c ? rem_sub_c[CNT_W-1:0] : rem_shift_c[CNT_W-1:0];
  assign quo_next_c  = {div_quo[SUM_W-2:0], rem_ge_c};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ACCUM;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM: if (frame_end_c) next_state = found_c ? DIV_X : DONE;
      DIV_X: if (last_step_c) next_state = DIV_Y;
      DIV_Y: if (last_step_c) next_state = DONE;
      DONE:  next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // Frame accumulators; a match in the frame-end cycle opens the next frame.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_q    <= 1'b1;
      cnt_acc <= '0;
      sx_acc  <= '0;
      sy_acc  <= '0;
    end else begin
      vs_q <= iVS;
      if (frame_end_c) begin
        cnt_acc <= match_c ? CNT_W'(1) : '0;
        sx_acc  <= match_c ? SUM_W'(iX) : '0;
        sy_acc  <= match_c ? SUM_W'(iY) : '0;
      end else if (match_c) begin
        cnt_acc <= cnt_inc_c;
        sx_acc  <= sx_inc_c;
        sy_acc  <= sy_inc_c;
      end
    end
  end

  // Snapshot, divider and result publication
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      snap_cnt <= '0;
      snap_sy  <= '0;
      div_quo  <= '0;
      div_rem  <= '0;
      step     <= '0;
      quot_x   <= '0;
      oMASK    <= 1'b0;
      oCX      <= '0;
      oCY      <= '0;
      oCOUNT   <= '0;
      oFOUND   <= 1'b0;
      oVALID   <= 1'b0;
      oBUSY    <= 1'b0;
      oDROP    <= 1'b0;
    end else begin
      oMASK  <= match_c;
      oVALID <= 1'b0;
      oDROP  <= frame_end_c && (state != ACCUM);
      oBUSY  <= next_state != ACCUM;
      case (state)
        ACCUM: begin
          if (frame_end_c) begin
            snap_cnt <= cnt_acc;
            snap_sy  <= sy_acc;
            div_quo  <= sx_acc;
            div_rem  <= '0;
            step     <= '0;
            if (!found_c) begin
              oVALID <= 1'b1;
              oCOUNT <= cnt_acc;
              oFOUND <= 1'b0;
            end
          end
        end
        DIV_X, DIV_Y: begin
          div_quo <= quo_next_c;
          div_rem <= rem_next_c;
          step    <= step + STEP_W'(1);
          if (last_step_c) begin
            step <= '0;
            if (state == DIV_X) begin
              quot_x  <= X_W'(quo_next_c);
              div_quo <= snap_sy;
              div_rem <= '0;
            end else begin
              oVALID <= 1'b1;
              oCOUNT <= snap_cnt;
              oFOUND <= 1'b1;
              oCX    <= quot_x;
              oCY    <= Y_W'(quo_next_c);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COLOUR_CENTROID_BBOX_EN
  logic [X_W-1:0] xmin_acc, xmax_acc, snap_xmin, snap_xmax;
  logic [Y_W-1:0] ymin_acc, ymax_acc, snap_ymin, snap_ymax;

  // Bounding box of matching pixels; min trackers restart at all-ones each frame.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      oXMIN     <= '0;
      oXMAX     <= '0;
      oYMIN     <= '0;
      oYMAX     <= '0;
    end else begin
      if (frame_end_c) begin
        xmin_acc <= match_c ? iX : '1;
        xmax_acc <= match_c ? iX : '0;
        ymin_acc <= match_c ? iY : '1;
        ymax_acc <= match_c ? iY : '0;
      end else if (match_c) begin
        if (iX < xmin_acc) xmin_acc <= iX;
        if (iX > xmax_acc) xmax_acc <= iX;
        if (iY < ymin_acc) ymin_acc <= iY;
        if (iY > ymax_acc) ymax_acc <= iY;
      end
      if (state == ACCUM && frame_end_c) begin
        snap_xmin <= xmin_acc;
        snap_xmax <= xmax_acc;
        snap_ymin <= ymin_acc;
        snap_ymax <= ymax_acc;
      end
      if (state == DIV_Y && last_step_c) begin
        oXMIN <= snap_xmin;
        oXMAX <= snap_xmax;
        oYMIN <= snap_ymin;
        oYMAX <= snap_ymax;
      end
    end
  end
`else
  assign oXMIN = '0;
  assign oXMAX = '0;
  assign oYMIN = '0;
  assign oYMAX = '0;
`endif

endmodule

// File: tb/tb_colour_centroid_tracker.sv
// Directed self-checking bench for colour_centroid_tracker (default parameters).
module tb_colour_centroid_tracker;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iDVAL;
  logic [10:0] iX, iY;
  logic        iVS;
  logic [7:0]  iH, iS, iV, iH_LO, iH_HI, iS_MIN, iV_MIN;
  logic        oMASK, oFOUND, oVALID, oBUSY, oDROP;
  logic [10:0] oCX, oCY, oXMIN, oXMAX, oYMIN, oYMAX;
  logic [18:0] oCOUNT;

  int checks = 0;
  int errors = 0;
  int lat;
  int cyc;

  colour_centroid_tracker dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDVAL(iDVAL), .iX(iX), .iY(iY), .iVS(iVS),
    .iH(iH), .iS(iS), .iV(iV), .iH_LO(iH_LO), .iH_HI(iH_HI),
    .iS_MIN(iS_MIN), .iV_MIN(iV_MIN),
    .oMASK(oMASK), .oCX(oCX), .oCY(oCY), .oCOUNT(oCOUNT), .oFOUND(oFOUND),
    .oVALID(oVALID), .oBUSY(oBUSY), .oDROP(oDROP),
    .oXMIN(oXMIN), .oXMAX(oXMAX), .oYMIN(oYMIN), .oYMAX(oYMAX)
  );

  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // After this returns, outputs reflect the cycle just clocked in.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic px(input int x, input int y, input int h, input int s, input int v);
    iDVAL = 1'b1;
    iX = 11'(x);
    iY = 11'(y);
    iH = 8'(h);
    iS = 8'(s);
    iV = 8'(v);
    tick();
  endtask

  // Frame end in the cycle after the last pixel; lat counts cycles from T to oVALID.
  task automatic end_frame(output int l);
    iDVAL = 1'b0;
    iVS = 1'b0;
    tick();
    iVS = 1'b1;
    l = 1;
    while (oVALID !== 1'b1 && l < 200) begin
      tick();
      l++;
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    iDVAL = 1'b0; iX = '0; iY = '0; iVS = 1'b1;
    iH = 8'd128; iS = '0; iV = '0;
    iH_LO = 8'd40; iH_HI = 8'd60; iS_MIN = '0; iV_MIN = '0;
    #23;
    check_eq("rst_mask", oMASK, 0);
    check_eq("rst_cx", oCX, 0);
    check_eq("rst_count", oCOUNT, 0);
    check_eq("rst_flags", {oFOUND, oVALID, oBUSY, oDROP}, 0);
    tick();
    iRST_N = 1'b1;
    tick();

    // Square hit: 10x10 block of H=50 inside rows of H=128
    iDVAL = 1'b0; iH = 8'd50; iX = '0; iY = '0;
    tick();
    check_eq("dval0_mask", oMASK, 0);
    for (int y = 200; y <= 209; y++)
      for (int x = 98; x <= 111; x++) begin
        px(x, y, (x >= 100 && x <= 109) ? 50 : 128, 0, 0);
        if (y == 200) check_eq("sq_mask", oMASK, (x >= 100 && x <= 109) ? 1 : 0);
      end
    iDVAL = 1'b0; iVS = 1'b0;
    tick();
    iVS = 1'b1;
    check_eq("sq_busy_t1", oBUSY, 1);
    check_eq("sq_drop_t1", oDROP, 0);
    lat = 1;
    while (oVALID !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check_eq("sq_latency", lat, 57);
    check_eq("sq_cx", oCX, 104);
    check_eq("sq_cy", oCY, 204);
    check_eq("sq_count", oCOUNT, 100);
    check_eq("sq_found", oFOUND, 1);
`ifdef COLOUR_CENTROID_BBOX_EN
    check_eq("sq_bbox", {oXMIN, oXMAX, oYMIN, oYMAX} , {11'd100, 11'd109, 11'd200, 11'd209});
`else
    check_eq("sq_bbox", {oXMIN, oXMAX, oYMIN, oYMAX} , 0);
`endif
    tick();
    check_eq("sq_valid_pulse", oVALID, 0);
    check_eq("sq_busy_end", oBUSY, 0);

    // Hue wrap window and S/V minimums; 5 matches here plus 58 more gives 63
    iH_LO = 8'd240; iH_HI = 8'd10;
    px(5, 7, 250, 0, 0); check_eq("wrap_250", oMASK, 1);
    px(5, 7, 5, 0, 0);   check_eq("wrap_5", oMASK, 1);
    px(5, 7, 128, 0, 0); check_eq("wrap_128", oMASK, 0);
    px(5, 7, 240, 0, 0); check_eq("wrap_240", oMASK, 1);
    px(5, 7, 10, 0, 0);  check_eq("wrap_10", oMASK, 1);
    px(5, 7, 11, 0, 0);  check_eq("wrap_11", oMASK, 0);
    px(5, 7, 239, 0, 0); check_eq("wrap_239", oMASK, 0);
    iS_MIN = 8'd100;
    px(5, 7, 0, 99, 0);  check_eq("smin_99", oMASK, 0);
    px(5, 7, 0, 100, 0); check_eq("smin_100", oMASK, 1);
    iS_MIN = 8'd0; iV_MIN = 8'd50;
    px(5, 7, 0, 0, 49);  check_eq("vmin_49", oMASK, 0);
    iV_MIN = 8'd0;
    for (int i = 0; i < 58; i++) px(5, 7, 0, 0, 0);
    end_frame(lat);
    check_eq("low_latency", lat, 1);
    check_eq("low_found", oFOUND, 0);
    check_eq("low_count", oCOUNT, 63);
    check_eq("low_cx_hold", oCX, 104);
    check_eq("low_cy_hold", oCY, 204);
    tick();

    // Exactly MIN_COUNT pixels, then a second frame end while dividing
    for (int i = 0; i < 64; i++) px(20, 30, 0, 0, 0);
    iDVAL = 1'b0; iVS = 1'b0;
    tick();
    iVS = 1'b1;
    cyc = 1;
    for (int i = 0; i < 3; i++) begin
      px(1, 1, 0, 0, 0);
      cyc++;
    end
    iDVAL = 1'b0;
    while (cyc < 20) begin
      tick();
      cyc++;
    end
    iVS = 1'b0;
    px(10, 6, 0, 0, 0);
    cyc++;
    iVS = 1'b1;
    check_eq("ovr_drop", oDROP, 1);
    px(8, 4, 0, 0, 0);
    cyc++;
    check_eq("ovr_drop_pulse", oDROP, 0);
    px(8, 4, 0, 0, 0);
    cyc++;
    iDVAL = 1'b0;
    while (oVALID !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq("ovr_latency", cyc, 57);
    check_eq("ovr_count", oCOUNT, 64);
    check_eq("ovr_found", oFOUND, 1);
    check_eq("ovr_cx", oCX, 20);
    check_eq("ovr_cy", oCY, 30);
`ifdef COLOUR_CENTROID_BBOX_EN
    check_eq("ovr_bbox", {oXMIN, oXMAX, oYMIN, oYMAX}, {11'd20, 11'd20, 11'd30, 11'd30});
`else
    check_eq("ovr_bbox", {oXMIN, oXMAX, oYMIN, oYMAX}, 0);
`endif
    tick();
    end_frame(lat);
    check_eq("next_latency", lat, 1);
    check_eq("next_count", oCOUNT, 3);
    check_eq("next_cx_hold", oCX, 20);
    tick();

    // Asynchronous reset mid-stream discards partial frame
    px(1, 1, 0, 0, 0);
    px(1, 1, 0, 0, 0);
    check_eq("pre_rst_mask", oMASK, 1);
    iRST_N = 1'b0;
    #1;
    check_eq("mid_rst_mask", oMASK, 0);
    check_eq("mid_rst_cx", {oCX, oCY}, 0);
    check_eq("mid_rst_count", oCOUNT, 0);
    iDVAL = 1'b0;
    tick();
    iRST_N = 1'b1;
    for (int i = 0; i < 4; i++) px(2, 3, 0, 0, 0);
    end_frame(lat);
    check_eq("post_rst_latency", lat, 1);
    check_eq("post_rst_found", oFOUND, 0);
    check_eq("post_rst_count", oCOUNT, 4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
